// File: rtl/pipe_pkg.sv
// pipe_pkg: shared field widths, per-boundary stage widths and EX/MEM packing offsets
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;
    localparam int MEM_WE_W   = 4;
    localparam int MEM_RW_W   = 2;
    localparam int ALU_OP_W   = 4;

    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 2 * WORD_W;
    localparam int EX_MEM_CTRL_W = 2 + MEM_WE_W + MEM_RW_W;
    localparam int EX_MEM_DATA_W = REG_ADDR_W + 2 * WORD_W;
    localparam int ID_EX_CTRL_W  = EX_MEM_CTRL_W + ALU_OP_W + 1;
    localparam int ID_EX_DATA_W  = 3 * REG_ADDR_W + 3 * WORD_W;
    localparam int MEM_WB_CTRL_W = 2;
    localparam int MEM_WB_DATA_W = REG_ADDR_W + 2 * WORD_W;

    localparam int EX_MEM_REG_WRITE_BIT  = 7;
    localparam int EX_MEM_MEM_TO_REG_BIT = 6;
    localparam int EX_MEM_MEM_WRITE_LSB  = 2;
    localparam int EX_MEM_MEM_RW_LSB     = 0;

    localparam int EX_MEM_WRITE_REG_LSB  = 2 * WORD_W;
    localparam int EX_MEM_WRITE_DATA_LSB = WORD_W;
    localparam int EX_MEM_ALU_OUT_LSB    = 0;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic [MEM_WE_W-1:0] mem_write;
        logic [MEM_RW_W-1:0] mem_read_width;
    } ex_mem_ctrl_t;

    function automatic logic [EX_MEM_DATA_W-1:0] pack_ex_mem_data(
        input logic [REG_ADDR_W-1:0] write_register,
        input logic [WORD_W-1:0]     write_data,
        input logic [WORD_W-1:0]     alu_out
    );
        return {write_register, write_data, alu_out};
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: one-entry skid register with a registered ready that never depends on downstream ready
module pipe_skid_buf #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 69
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              skid_valid,
    output logic [CTRL_W-1:0] skid_ctrl,
    output logic [DATA_W-1:0] skid_data,
    output logic              ready
);

    // push only happens while ready is high, so a held entry is never overwritten
    always_ff @(posedge clock) begin
        if (reset) begin
            skid_valid <= 1'b0;
            ready      <= 1'b1;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
            ready      <= 1'b1;
        end else if (push) begin
            skid_valid <= 1'b1;
            ready      <= 1'b0;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end else if (pop) begin
            skid_valid <= 1'b0;
            ready      <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, bubble-safe ctrl and stall counter; PIPE_SKID_EN adds a skid entry and registered in_ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_count
);

    logic              valid_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [DATA_W-1:0] data_reg;
    logic              load;
    logic              accept;
    logic              src_valid;
    logic [CTRL_W-1:0] src_ctrl;
    logic [DATA_W-1:0] src_data;

    assign load   = !valid_reg || out_ready;
    assign accept = in_valid && in_ready;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    pipe_skid_buf #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (accept && !load),
        .pop       (load),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .skid_valid(skid_valid),
        .skid_ctrl (skid_ctrl),
        .skid_data (skid_data),
        .ready     (in_ready)
    );

    assign src_valid = skid_valid || accept;
    assign src_ctrl  = skid_valid ? skid_ctrl : in_ctrl;
    assign src_data  = skid_valid ? skid_data : in_data;
`else
    assign in_ready  = load;
    assign src_valid = accept;
    assign src_ctrl  = in_ctrl;
    assign src_data  = in_data;
`endif

    // main register refills whenever it is empty or its beat leaves this cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            data_reg  <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= src_valid;
            if (src_valid) begin
                ctrl_reg <= src_ctrl;
                data_reg <= src_data;
            end
        end
    end

    // saturating count of cycles a beat waited on downstream; only reset clears it
    always_ff @(posedge clock) begin
        if (reset)
            stall_count <= '0;
        else if (valid_reg && !out_ready && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end

    assign out_valid = valid_reg;
    assign out_ctrl  = valid_reg ? ctrl_reg : '0;
    assign out_data  = data_reg;

endmodule
